// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle phase sequencer for the 10-bit processor.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// instruction/data memory handshakes, gates IR/PC/register-file writes,
// and adds sticky HALT and memory-timeout FAULT states.
module cpu_sequencer #(
  parameter int          MEM_TIMEOUT = 64,
  parameter int          CNT_W       = 16,
  parameter logic [3:0]  HALT_OP     = 4'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Run,
  input  logic [3:0]       Opcode,
  input  logic             RegWriteFlag,
  input  logic             MemReadFlag,
  input  logic             MemWriteFlag,
  input  logic             BranchTaken,
  input  logic             IMemAck,
  input  logic             DMemAck,
  output logic             IMemReq,
  output logic             IRWrite,
  output logic             ALUEnable,
  output logic             DMemReq,
  output logic             DMemWe,
  output logic             RegWriteEn,
  output logic             PCWrite,
  output logic             PCSel,
  output logic [2:0]       Phase,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              rw_q, rw_d;
  logic              mr_q, mr_d;
  logic              mw_q, mw_d;
  logic [31:0]       wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ir_write_s;
  logic              reg_we_s;
  logic              pc_write_s;
  logic              pc_sel_s;
  logic              timeout_s;

  // The wait counter expires on its last permitted wait cycle; a zero limit disables it.
  assign timeout_s = (MEM_TIMEOUT != 0) && (wait_q == 32'(MEM_TIMEOUT - 1));

  // State register plus latched decoder flags, wait counter and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      wait_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and the combinational write strobes (Mealy on acks/branch).
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    mr_d       = mr_q;
    mw_d       = mw_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    ir_write_s = 1'b0;
    reg_we_s   = 1'b0;
    pc_write_s = 1'b0;
    pc_sel_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Run) begin
          state_d = S_FETCH;
          wait_d  = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        if (IMemAck) begin
          ir_write_s = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      S_DECODE: begin
        rw_d = RegWriteFlag;
        mr_d = MemReadFlag;
        mw_d = MemWriteFlag;
        if (Opcode == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (mr_q || mw_q) begin
          state_d = S_MEM;
          wait_d  = 32'd0;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        if (DMemAck) begin
          state_d = S_WB;
        end else if (timeout_s) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end

      S_WB: begin
        reg_we_s   = rw_q;
        pc_write_s = 1'b1;
        pc_sel_s   = BranchTaken;
        cnt_d      = cnt_q + CNT_W'(1);
        if (Run) begin
          state_d = S_FETCH;
          wait_d  = 32'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // Moore outputs decoded straight from the state so reset clears them asynchronously.
  assign IMemReq    = (state_q == S_FETCH);
  assign ALUEnable  = (state_q == S_EXEC);
  assign DMemReq    = (state_q == S_MEM);
  assign DMemWe     = (state_q == S_MEM) && mw_q;
  assign Halted     = (state_q == S_HALT);
  assign Fault      = (state_q == S_FAULT);
  assign Phase      = state_q;
  assign InstrCount = cnt_q;

  assign IRWrite    = ir_write_s;
  assign RegWriteEn = reg_we_s;
  assign PCWrite    = pc_write_s;
  assign PCSel      = pc_sel_s;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle phase sequencer for the 10-bit processor. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the instruction-memory and data-memory request/acknowledge handshakes. It gates the instruction-register, PC and register-file write enables using the control flags produced by the opcode decoder. It sits between the decoder, the memories and the PC/register-file write ports, and adds halt detection and a memory-timeout fault.

## Interface

Parameters:
- MEM_TIMEOUT, 64: maximum wait cycles for an acknowledge; 0 disables the timeout.
- CNT_W, 16: width of the retired-instruction counter.
- HALT_OP, 15: opcode that halts the sequencer.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Run  in  1  level; permits starting or continuing execution.
- Opcode  in  4  opcode field of the held instruction register.
- RegWriteFlag  in  1  decoder: instruction writes the register file.
- MemReadFlag  in  1  decoder: instruction reads data memory.
- MemWriteFlag  in  1  decoder: instruction writes data memory.
- BranchTaken  in  1  from ALU/branch logic; valid in EXEC and WB.
- IMemAck  in  1  instruction memory has returned data.
- DMemAck  in  1  data memory has completed the access.
- IMemReq  out  1  instruction fetch request.
- IRWrite  out  1  load the instruction register.
- ALUEnable  out  1  execute phase strobe.
- DMemReq  out  1  data memory request.
- DMemWe  out  1  data memory write, qualified by DMemReq.
- RegWriteEn  out  1  register-file write strobe.
- PCWrite  out  1  PC update strobe.
- PCSel  out  1  1 selects the branch destination; 0 selects PC+1.
- Phase  out  3  current state encoding.
- Halted  out  1  in HALT.
- Fault  out  1  in FAULT.
- InstrCount  out  CNT_W  number of retired instructions.

## Operation

State encoding:
- IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6, FAULT = 7.

Reset:
- The state goes to IDLE.
- All outputs go to 0, including InstrCount, the latched flags and the wait counter.

Transitions:
- IDLE: if Run = 1, go to FETCH; otherwise stay.
- FETCH: IMemReq = 1.
  - On IMemAck: IRWrite = 1 in that same cycle, then go to DECODE.
- DECODE: one cycle.
  - Latch RegWriteFlag, MemReadFlag and MemWriteFlag internally.
  - If Opcode == HALT_OP, go to HALT; otherwise go to EXEC.
- EXEC: one cycle with ALUEnable = 1.
  - If latched MemRead or MemWrite is set, go to MEM; otherwise go to WB.
- MEM: DMemReq = 1 and DMemWe = latched MemWrite.
  - On DMemAck, go to WB.
  - If both latched flags are set, the access is treated as a write.
- WB: one cycle.
  - RegWriteEn = latched RegWrite, PCWrite = 1, PCSel = BranchTaken.
  - InstrCount increments and wraps modulo 2^CNT_W.
  - Next state is FETCH if Run = 1, otherwise IDLE.
- HALT and FAULT: all strobes are 0. Both states are sticky and exit only through rst_n.

Outputs:
- IMemReq, DMemReq, DMemWe, ALUEnable and Halted/Fault are decoded from the state (Moore).
- IRWrite, RegWriteEn, PCWrite and PCSel are combinational in the states listed above and 0 everywhere else.

Wait counter:
- Cleared on entry to FETCH and on entry to MEM.
- Increments on each FETCH or MEM cycle that has no acknowledge.
- If it reaches MEM_TIMEOUT−1 with no acknowledge in that cycle, the next state is FAULT.
- An acknowledge in the same cycle as the timeout wins; no fault is raised.

Boundary behaviour:
- IMemAck outside FETCH and DMemAck outside MEM are ignored.
- Run deasserting mid-instruction does not abort it. The instruction completes, and the sequencer goes to IDLE after WB.
- Reset asserted mid-handshake drops the request immediately, asynchronously.

## Timing

- Non-memory instruction with a zero-wait acknowledge: 4 cycles (FETCH, DECODE, EXEC, WB).
- Memory instruction: 5 cycles plus the DMemAck wait.
- Each fetch wait cycle adds 1 cycle.
- Back-to-back execution with Run held high: FETCH follows WB with no bubble.
- Idle start latency: 1 cycle from Run = 1 in IDLE to IMemReq = 1.
- Requests stay asserted continuously until their acknowledge, or until the transition to FAULT.
- InstrCount reflects the increment in the cycle after WB.

## Test plan

- **Reset:** rst_n = 0 mid-MEM → Phase = 0, DMemReq = 0 and InstrCount = 0 immediately, without waiting for a clock edge.
- **Basic sequence:** Run = 1, acks immediate, Opcode = 2, RegWriteFlag = 1 → Phase 1, 2, 3, 5; RegWriteEn = 1 and PCWrite = 1 in WB; InstrCount = 1; the next FETCH follows directly.
- **Memory write with wait:** Opcode = 0, MemWriteFlag = 1, DMemAck after 3 cycles → DMemReq and DMemWe held high for 4 cycles, then WB; total 8 cycles.
- **Branch and halt:**
  - BranchTaken = 1 in WB → PCSel = 1 together with PCWrite = 1.
  - Opcode = 15 at DECODE → HALT with Halted = 1; Run toggling has no effect.
- **Timeout:** MEM_TIMEOUT = 4, IMemAck never asserted → FAULT after 4 FETCH cycles. A repeat run with the ack arriving in the 4th cycle reaches DECODE with no fault.
- **Run drop and counter wrap:**
  - Run → 0 during EXEC: WB completes, then IDLE with no IMemReq.
  - CNT_W = 2 after 4 retired instructions → InstrCount = 0.
